// File: rtl/seg_scan_display_if.sv
// Bundle between a value producer and the seg_scan_display driver.
// hex_mode exists only when SEG_HEX_MODE_EN is defined.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
);
  logic [BIN_W-1:0]      value_in;
  logic                  value_load;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic                  blank_lz;
  logic                  blink_en;
`ifdef SEG_HEX_MODE_EN
  logic                  hex_mode;
`endif
  logic                  busy;
  logic                  overflow;
  logic [NUM_DIGITS-1:0] seg_sel;
  logic [7:0]            seg_data;

  // Load handshake: value_load is a single-cycle request that is accepted only
  // while busy=0; a request seen while busy=1 is dropped, never queued.
  modport master (
    output value_in, value_load, dp_mask, blank_lz, blink_en,
`ifdef SEG_HEX_MODE_EN
    output hex_mode,
`endif
    input  busy, overflow, seg_sel, seg_data
  );

  modport slave (
    input  value_in, value_load, dp_mask, blank_lz, blink_en,
`ifdef SEG_HEX_MODE_EN
    input  hex_mode,
`endif
    output busy, overflow, seg_sel, seg_data
  );
endinterface

// File: rtl/seg_scan_display.sv
// N-digit multiplexed 7-segment driver: double-dabble BCD conversion, then digit scan.
// Define SEG_HEX_MODE_EN to add the hex_mode input (raw nibble load, glyphs A-F).
module seg_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int BIN_W          = 14,
  parameter int SCAN_DIV       = 50_000,
  parameter int BLINK_DIV      = 25_000_000,
  parameter bit SEL_ACTIVE_LOW = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  seg_scan_display_if.slave bus,
  output logic [1:0]        dbg_state
);
  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BIN_W - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [63:0] pow_u64(input int base, input int expo);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < expo; k++) r = r * 64'(base);
    return r;
  endfunction

  localparam logic [63:0] DEC_LIMIT = pow_u64(10, NUM_DIGITS);

  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    logic [7:0] c;
    case (nib)
      4'd0: c = 8'h3F;  4'd1: c = 8'h06;  4'd2: c = 8'h5B;  4'd3: c = 8'h4F;
      4'd4: c = 8'h66;  4'd5: c = 8'h6D;  4'd6: c = 8'h7D;  4'd7: c = 8'h07;
      4'd8: c = 8'h7F;  4'd9: c = 8'h6F;
`ifdef SEG_HEX_MODE_EN
      4'd10: c = 8'h77; 4'd11: c = 8'h7C; 4'd12: c = 8'h39;
      4'd13: c = 8'h5E; 4'd14: c = 8'h79; 4'd15: c = 8'h71;
`endif
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BIN_W-1:0]       bin_q;
  logic [BCD_W-1:0]       bcd_q, bcd_adj, disp_q;
  logic [CNT_W-1:0]       shift_cnt_q;
  logic                   ovf_next_q, ovf_q;
  logic [63:0]            val_ext, ovf_limit;
  logic                   hex_sel;
  logic [BCD_W+BIN_W:0]   shifted;

  assign val_ext = 64'(bus.value_in);

`ifdef SEG_HEX_MODE_EN
  localparam logic [63:0] HEX_LIMIT = pow_u64(16, NUM_DIGITS);
  assign hex_sel   = bus.hex_mode;
  assign ovf_limit = hex_sel ? HEX_LIMIT : DEC_LIMIT;
`else
  assign hex_sel   = 1'b0;
  assign ovf_limit = DEC_LIMIT;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.value_load) state_d = hex_sel ? S_COMMIT : S_SHIFT;
      S_SHIFT:  if (shift_cnt_q == CNT_LAST) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy  = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, bin_q, 1'b0};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bin_q       <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
      ovf_next_q  <= 1'b0;
      disp_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.value_load) begin
          bin_q       <= bus.value_in;
          bcd_q       <= hex_sel ? val_ext[BCD_W-1:0] : '0;
          ovf_next_q  <= (val_ext >= ovf_limit);
          shift_cnt_q <= '0;
        end
        S_SHIFT: begin
          bcd_q       <= shifted[BCD_W+BIN_W-1:BIN_W];
          bin_q       <= shifted[BIN_W-1:0];
          shift_cnt_q <= shift_cnt_q + CNT_W'(1);
          // A carry out of the top nibble also means the value did not fit.
          ovf_next_q  <= ovf_next_q | shifted[BCD_W+BIN_W];
        end
        S_COMMIT: begin
          disp_q <= bcd_q;
          ovf_q  <= ovf_next_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.overflow = ovf_q;

  logic [SCAN_W-1:0]     scan_cnt_q;
  logic [BLINK_W-1:0]    blink_cnt_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  phase_q, phase_d, scan_wrap, blink_wrap;
  logic [NUM_DIGITS-1:0] sel_d, sel_q;
  logic [7:0]            glyph_d, data_q;
  logic [3:0]            nib_i, cur_nib;
  logic                  all_zero, cur_blank, cur_dp;

  assign scan_wrap  = (scan_cnt_q == SCAN_LAST);
  assign blink_wrap = (blink_cnt_q == BLINK_LAST);
  assign idx_d      = scan_wrap ? ((idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1)) : idx_q;
  assign phase_d    = phase_q ^ blink_wrap;

  // Outputs are built from the next index/phase so select and data move together.
  always_comb begin
    all_zero  = 1'b1;
    nib_i     = 4'd0;
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_i    = disp_q[4*(NUM_DIGITS-1-i) +: 4];
      all_zero = all_zero && (nib_i == 4'd0);
      if (idx_d == IDX_W'(i)) begin
        cur_nib   = nib_i;
        cur_blank = bus.blank_lz && all_zero && (i != NUM_DIGITS - 1);
        cur_dp    = bus.dp_mask[i];
      end
    end
    if (ovf_q)          glyph_d = 8'h40;
    else if (cur_blank) glyph_d = 8'h00;
    else                glyph_d = seg_code(cur_nib);
    glyph_d[7] = glyph_d[7] | cur_dp;

    sel_d        = '0;
    sel_d[idx_d] = 1'b1;
    if (bus.blink_en && phase_d) sel_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      sel_q       <= NUM_DIGITS'(1);
      data_q      <= 8'h00;
    end else begin
      scan_cnt_q  <= scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
      blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      sel_q       <= sel_d;
      data_q      <= glyph_d;
    end
  end

  assign bus.seg_sel  = sel_q ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
  assign bus.seg_data = data_q ^ {8{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (4 digits, 14-bit input, SCAN_DIV=4, BLINK_DIV=8).
module tb_seg_scan_display;
  logic       clk;
  logic       rstn;
  logic [1:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];   // {seg_sel, seg_data} per digit, in scan order

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  seg_scan_display_if #(.NUM_DIGITS(4), .BIN_W(14)) bus();

  seg_scan_display #(
    .NUM_DIGITS(4), .BIN_W(14), .SCAN_DIV(4), .BLINK_DIV(8),
    .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard model: expected glyph per digit for a committed value.
  task automatic push_expected(input int v, input bit blank, input logic [3:0] dp);
    int  div;
    int  dig;
    bit  allz;
    logic [7:0] g;
    logic [3:0] sel;
    div  = 1000;
    allz = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dig  = (v / div) % 10;
      div  = div / 10;
      allz = allz && (dig == 0);
      if (v >= 10000)              g = 8'h40;
      else if (blank && allz && i != 3) g = 8'h00;
      else                         g = seg_tab[dig];
      g[7] = g[7] | dp[i];
      sel  = 4'b0001 << i;
      exp_q.push_back({sel, g});
    end
  endtask

  // Wait for the scan to enter digit 0, then compare every held cycle.
  task automatic check_scan(input string tag);
    logic [3:0]  prev;
    logic [11:0] e;
    bit found;
    found = 1'b0;
    prev  = bus.seg_sel;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.seg_sel == 4'b0001 && prev != 4'b0001) begin
        found = 1'b1;
        break;
      end
      prev = bus.seg_sel;
    end
    check({tag, " sync"}, 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < 16; k++) begin
        if (k > 0) @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q[0] : 12'hFFF;
        check($sformatf("%s sel d%0d", tag, k / 4), 32'(bus.seg_sel), 32'(e[11:8]));
        check($sformatf("%s data d%0d", tag, k / 4), 32'(bus.seg_data), 32'(e[7:0]));
        if (k % 4 == 3 && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    exp_q.delete();
  endtask

  // Driver: pulse value_load, count busy cycles, optionally re-pulse while busy.
  task automatic load(input int v, input int extra_at, input int extra_v, output int busy_cycles);
    @(negedge clk);
    bus.value_in   = 14'(v);
    bus.value_load = 1'b1;
    @(negedge clk);
    bus.value_load = 1'b0;
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      if (busy_cycles == extra_at) begin
        bus.value_in   = 14'(extra_v);
        bus.value_load = 1'b1;
      end else begin
        bus.value_load = 1'b0;
      end
      @(negedge clk);
    end
    bus.value_load = 1'b0;
  endtask

  task automatic load_and_scan(input string tag, input int v, input bit blank, input logic [3:0] dp);
    int bc;
    load(v, 0, 0, bc);
    check({tag, " busy_len"}, 32'(bc), 32'd15);
    check({tag, " overflow"}, 32'(bus.overflow), 32'(v >= 10000));
    push_expected(v, blank, dp);
    check_scan(tag);
  endtask

  initial begin
    int  bc;
    int  cnt;
    bit  found;
    logic [3:0] prev;

    rstn           = 1'b0;
    bus.value_in   = '0;
    bus.value_load = 1'b0;
    bus.dp_mask    = '0;
    bus.blank_lz   = 1'b0;
    bus.blink_en   = 1'b0;
`ifdef SEG_HEX_MODE_EN
    bus.hex_mode   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    check("rst seg_sel", 32'(bus.seg_sel), 32'h1);
    check("rst seg_data", 32'(bus.seg_data), 32'h00);
    check("rst state", 32'(dbg_state), 32'd0);
    rstn = 1'b1;

    load_and_scan("v1234", 1234, 1'b0, 4'b0000);

    bus.blank_lz = 1'b1;
    load_and_scan("lz7", 7, 1'b1, 4'b0000);
    load_and_scan("lz0", 0, 1'b1, 4'b0000);
    bus.dp_mask = 4'b0100;
    push_expected(0, 1'b1, 4'b0100);
    check_scan("dp2");
    bus.dp_mask  = 4'b0000;
    bus.blank_lz = 1'b0;

    load_and_scan("ovf12000", 12000, 1'b0, 4'b0000);
    load_and_scan("v9999", 9999, 1'b0, 4'b0000);

    // A second request during busy must be dropped.
    load(1111, 0, 0, bc);
    load(9999, 3, 5, bc);
    check("drop busy_len", 32'(bc), 32'd15);
    repeat (2) @(negedge clk);
    check("drop busy_after", 32'(bus.busy), 32'd0);
    push_expected(9999, 1'b0, 4'b0000);
    check_scan("drop");

    // Blink: sync on the end of a dark phase, then expect 8 lit / 8 dark / 8 lit.
    bus.blink_en = 1'b1;
    found = 1'b0;
    prev  = bus.seg_sel;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.seg_sel != 4'b0000 && prev == 4'b0000) begin
        found = 1'b1;
        break;
      end
      prev = bus.seg_sel;
    end
    check("blink sync", 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < 24; k++) begin
        if (k > 0) @(negedge clk);
        check($sformatf("blink lit c%0d", k), 32'(bus.seg_sel != 4'b0000),
              32'((k / 8) != 1));
      end
    end
    bus.blink_en = 1'b0;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (bus.seg_sel != 4'b0000) cnt++;
      @(negedge clk);
    end
    check("noblink lit_cycles", 32'(cnt), 32'd24);

    // Reset in the middle of a conversion aborts it and clears the display.
    @(negedge clk);
    bus.value_in   = 14'd4321;
    bus.value_load = 1'b1;
    @(negedge clk);
    bus.value_load = 1'b0;
    cnt = 1;
    while (cnt < 6 && bus.busy === 1'b1) begin
      @(negedge clk);
      cnt++;
    end
    check("abort busy_at6", 32'(bus.busy), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort seg_sel", 32'(bus.seg_sel), 32'h1);
    check("abort seg_data", 32'(bus.seg_data), 32'h00);
    check("abort overflow", 32'(bus.overflow), 32'd0);
    rstn = 1'b1;
    push_expected(0, 1'b0, 4'b0000);
    check_scan("abort");
    check("abort idle", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised N-digit multiplexed 7-segment driver; successor to the fixed 4-digit display wrapper.
- Converts a binary value to BCD with an iterative double-dabble FSM (load/busy handshake), then scans digits one at a time.
- Adds leading-zero blanking, per-digit decimal points, whole-display blinking, overflow indication and configurable output polarity.
- Sits between result/statistics logic (time, coordinates, peak value) and the board's seg_sel/seg_data pins.

Parameters:
NUM_DIGITS, 4, number of digits (2..8); digit 0 is the leftmost / most significant
BIN_W, 14, width of the binary input value
SCAN_DIV, 50_000, clk cycles each digit is held before the scan advances
BLINK_DIV, 25_000_000, clk cycles per blink half-period
SEL_ACTIVE_LOW, 0, 1 = invert seg_sel at the output
SEG_ACTIVE_LOW, 0, 1 = invert seg_data at the output

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
value_in  in  BIN_W  binary value to display
value_load  in  1  single-cycle request to convert value_in
dp_mask  in  NUM_DIGITS  bit i lights the decimal point of digit i
blank_lz  in  1  enable leading-zero blanking
blink_en  in  1  enable whole-display blinking
busy  out  1  conversion in progress
overflow  out  1  last committed value needs more than NUM_DIGITS decimal digits
seg_sel  out  NUM_DIGITS  one-hot digit select; bit i selects digit i
seg_data  out  8  segments {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset values (rstn low at a clk edge):
  - FSM returns to IDLE; busy=0, overflow=0.
  - Display register = all digits 0.
  - Scan counter, blink counter, digit index and blink phase = 0.
  - seg_sel = one-hot digit 0; seg_data = 8'h00 (both after polarity inversion).
  - Reset during a conversion aborts it; nothing is committed.
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: when value_load=1, capture value_in. overflow_next = (value_in >= 10^NUM_DIGITS), with 10^NUM_DIGITS computed as an elaboration-time constant. Clear the BCD accumulator (4*NUM_DIGITS bits). Go to SHIFT. busy=1 from the next cycle.
  - SHIFT: exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by one. After the BIN_W-th cycle go to COMMIT.
  - COMMIT: copy the accumulator into the display register and overflow_next into overflow; go to IDLE.
  - busy is high for BIN_W+1 cycles. New digits are visible on the first scan update after COMMIT.
  - value_load while busy=1 is dropped, with no queueing.
  - value_load at reset release is honoured on the first clk edge with rstn=1.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index increments modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
  - seg_sel and seg_data are both registered and always change on the same edge; no cycle of misalignment.
- Glyph for digit i:
  - overflow=1: 8'h40 ('-') on every digit.
  - Else, blanked if blank_lz=1, digits 0..i are all zero, and i != NUM_DIGITS-1; blanked glyph = 8'h00. The last digit always shows, so a value of 0 displays as "0".
  - Else, standard codes 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Bit 7 is then ORed with dp_mask[i]; the decimal point also shows on blanked digits.
- Blink:
  - Blink counter runs 0..BLINK_DIV-1; blink phase toggles on each wrap, independent of blink_en.
  - When blink_en=1 and phase=1, all seg_sel bits are inactive; the scan keeps running.
- Polarity: inversion is applied last, on the registered outputs.

Optional Feature:
- Macro SEG_HEX_MODE_EN.
- Defined:
  - Adds input hex_mode (1 bit).
  - When hex_mode=1 at value_load, skip SHIFT. COMMIT occurs the next cycle (busy high 1 cycle) and loads the low 4*NUM_DIGITS bits of value_in as raw nibbles.
  - Glyphs A-F are 77 7C 39 5E 79 71.
  - overflow = (value_in >= 16^NUM_DIGITS).
- Undefined: no hex_mode port; always decimal; nibbles above 9 cannot occur.

Test Plan:
(All with NUM_DIGITS=4, BIN_W=14, SCAN_DIV=4, BLINK_DIV=8, polarities 0.)
- Load 1234 -> busy high 15 cycles; then seg_sel 0001/0010/0100/1000 each held 4 cycles with seg_data 06/5B/4F/66; overflow=0.
- blank_lz=1, load 7 -> digits 0-2 show 00, digit 3 shows 07. Load 0 -> 00,00,00,3F. dp_mask=0100 -> digit 2 shows 80.
- Load 12000 -> overflow=1 and all digits show 40. Then load 9999 -> overflow=0, digits show 6F x4.
- Load 9999, then value_load with 5 at cycle 3 of busy -> second load ignored; display 9999; busy drops after 15 cycles total.
- blink_en=1 -> seg_sel is 0000 for 8 cycles, scanning for 8 cycles, repeating. blink_en=0 -> continuous scan.
- Load 4321, rstn low at busy cycle 6 -> next cycle busy=0, seg_sel=0001, seg_data=00. After release, digits show 3F x4.
